// File: rtl/video_pkg.sv
// Shared types and defaults for the video frame controller: FSM state
// encoding, reset timing/step/centre values and the config shadow layout.
package video_pkg;

  typedef enum logic [1:0] {
    ST_SYNC   = 2'd0,
    ST_VBLANK = 2'd1,
    ST_ACTIVE = 2'd2
  } state_e;

  localparam int unsigned H_ACTIVE_DEF = 1920;
  localparam int unsigned V_ACTIVE_DEF = 1080;
  localparam int unsigned STEP_A_DEF   = 655;
  localparam int unsigned STEP_B_DEF   = 328;
  localparam int unsigned CX_DEF       = 960;
  localparam int unsigned CY_DEF       = 540;

  typedef struct packed {
    logic [15:0] step_a;
    logic [15:0] step_b;
    logic [11:0] cx;
    logic [11:0] cy;
  } cfg_t;

endpackage

// File: rtl/video_blank_edge.sv
// Rise/fall detection on {Vblank, Hblank} against the value seen on the
// previous enabled video cycle.
module video_blank_edge (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       cen_i,
  input  logic [1:0] vh_blank_i,
  output logic       h_r_o,
  output logic       h_f_o,
  output logic       v_r_o,
  output logic       v_f_o
);

  logic [1:0] prev_q;

  // Reset to "both blanking" so a blank level present at reset release never
  // looks like a rising edge; a fresh Vblank rise is needed to relock.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      prev_q <= 2'b11;
    end else if (cen_i) begin
      prev_q <= vh_blank_i;
    end
  end

  assign h_r_o = vh_blank_i[0] & ~prev_q[0];
  assign h_f_o = ~vh_blank_i[0] & prev_q[0];
  assign v_r_o = vh_blank_i[1] & ~prev_q[1];
  assign v_f_o = ~vh_blank_i[1] & prev_q[1];

endmodule

// File: rtl/video_frame_ctrl.sv
// Frame timing tracker with per-frame rotation angles and a vblank-synchronised
// config shadow. Define VIDEO_FRAME_CTRL_CHECK_EN to build the line/frame length checker.
module video_frame_ctrl
  import video_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE   = V_ACTIVE_DEF,
  parameter int unsigned DEF_STEP_A = STEP_A_DEF,
  parameter int unsigned DEF_STEP_B = STEP_B_DEF,
  parameter int unsigned DEF_CX     = CX_DEF,
  parameter int unsigned DEF_CY     = CY_DEF
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cen_i,
  input  logic [1:0]  vh_blank_i,
  input  logic        cfg_valid_i,
  output logic        cfg_ready_o,
  input  logic [15:0] cfg_step_a_i,
  input  logic [15:0] cfg_step_b_i,
  input  logic [11:0] cfg_cx_i,
  input  logic [11:0] cfg_cy_i,
  output logic [11:0] pix_x_o,
  output logic [11:0] pix_y_o,
  output logic        active_o,
  output logic        frame_start_o,
  output logic [15:0] angle_a_o,
  output logic [15:0] angle_b_o,
  output logic [11:0] cx_o,
  output logic [11:0] cy_o,
  output logic [15:0] frame_cnt_o,
  output logic        timing_err_o
);

  logic h_r, h_f, v_r, v_f;
  logic hblank, vblank;

  state_e      state_q, state_d;
  logic [11:0] pix_x_q, pix_x_d;
  logic [11:0] pix_y_q, pix_y_d;
  logic        active_q, active_d;
  logic        frame_start_q, frame_start_d;
  logic [15:0] angle_a_q, angle_a_d;
  logic [15:0] angle_b_q, angle_b_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  cfg_t        live_q, live_d;
  cfg_t        shadow_q, shadow_d;
  logic        pending_q, pending_d;
  cfg_t        cfg_in;
  cfg_t        cfg_reset;

  assign hblank    = vh_blank_i[0];
  assign vblank    = vh_blank_i[1];
  assign cfg_in    = '{step_a: cfg_step_a_i, step_b: cfg_step_b_i, cx: cfg_cx_i, cy: cfg_cy_i};
  assign cfg_reset = '{step_a: 16'(DEF_STEP_A), step_b: 16'(DEF_STEP_B),
                       cx: 12'(DEF_CX), cy: 12'(DEF_CY)};

  video_blank_edge u_edge (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .cen_i      (cen_i),
    .vh_blank_i (vh_blank_i),
    .h_r_o      (h_r),
    .h_f_o      (h_f),
    .v_r_o      (v_r),
    .v_f_o      (v_f)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= ST_SYNC;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      active_q      <= 1'b0;
      frame_start_q <= 1'b0;
      angle_a_q     <= '0;
      angle_b_q     <= '0;
      frame_cnt_q   <= '0;
      live_q        <= cfg_reset;
      shadow_q      <= '0;
      pending_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      active_q      <= active_d;
      frame_start_q <= frame_start_d;
      angle_a_q     <= angle_a_d;
      angle_b_q     <= angle_b_d;
      frame_cnt_q   <= frame_cnt_d;
      live_q        <= live_d;
      shadow_q      <= shadow_d;
      pending_q     <= pending_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pix_x_d       = pix_x_q;
    pix_y_d       = pix_y_q;
    active_d      = active_q;
    frame_start_d = frame_start_q;
    angle_a_d     = angle_a_q;
    angle_b_d     = angle_b_q;
    frame_cnt_d   = frame_cnt_q;
    live_d        = live_q;
    shadow_d      = shadow_q;
    pending_d     = pending_q;

    if (cen_i) begin
      unique case (state_q)
        ST_SYNC:   if (v_r) state_d = ST_VBLANK;
        ST_VBLANK: if (v_f) state_d = ST_ACTIVE;
        ST_ACTIVE: if (v_r) state_d = ST_VBLANK;
        default:   state_d = ST_SYNC;
      endcase

      if (h_f) begin
        pix_x_d = '0;
      end else if (!hblank && pix_x_q != 12'hFFF) begin
        pix_x_d = pix_x_q + 12'd1;
      end

      if (v_f) begin
        pix_y_d = '0;
      end else if (h_r && !vblank && state_q == ST_ACTIVE) begin
        pix_y_d = pix_y_q + 12'd1;
      end

      // Uses the next state so active_o lines up with pix_x_o on the first pixel.
      active_d      = (state_d == ST_ACTIVE) && !vblank && !hblank;
      frame_start_d = v_r;

      if (v_r && state_q != ST_SYNC) begin
        angle_a_d   = angle_a_q + live_q.step_a;
        angle_b_d   = angle_b_q + live_q.step_b;
        frame_cnt_d = frame_cnt_q + 16'd1;
      end

      // Ready is low while pending, so acceptance and apply never coincide.
      if (v_r && pending_q) begin
        live_d    = shadow_q;
        pending_d = 1'b0;
      end else if (cfg_valid_i && !pending_q) begin
        shadow_d  = cfg_in;
        pending_d = 1'b1;
      end
    end
  end

  assign pix_x_o       = pix_x_q;
  assign pix_y_o       = pix_y_q;
  assign active_o      = active_q;
  assign frame_start_o = frame_start_q;
  assign angle_a_o     = angle_a_q;
  assign angle_b_o     = angle_b_q;
  assign frame_cnt_o   = frame_cnt_q;
  assign cx_o          = live_q.cx;
  assign cy_o          = live_q.cy;
  assign cfg_ready_o   = ~pending_q;

`ifdef VIDEO_FRAME_CTRL_CHECK_EN
  localparam logic [12:0] H_CNT = 13'(H_ACTIVE);
  localparam logic [11:0] V_CNT = 12'(V_ACTIVE);

  logic        err_q, err_d;
  logic [12:0] line_pix;

  // pix_x_q holds the last active pixel index when Hblank rises.
  always_comb begin
    err_d    = err_q;
    line_pix = {1'b0, pix_x_q} + 13'd1;
    if (cen_i && state_q == ST_ACTIVE) begin
      if (h_r && !vblank && line_pix != H_CNT) err_d = 1'b1;
      if (v_r && pix_y_q != V_CNT) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign timing_err_o = err_q;
`else
  assign timing_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_video_frame_ctrl.sv
// Directed bench for video_frame_ctrl on a reduced 16x4 raster; expected
// timing_err_o follows whether VIDEO_FRAME_CTRL_CHECK_EN is defined.
module tb_video_frame_ctrl;
  import video_pkg::*;

  localparam int H  = 16;
  localparam int V  = 4;
  localparam int HB = 4;
  localparam int VB = 2;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        cen;
  logic [1:0]  vh_blank;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [15:0] cfg_step_a, cfg_step_b;
  logic [11:0] cfg_cx, cfg_cy;
  logic [11:0] pix_x_o, pix_y_o;
  logic        active_o, frame_start_o;
  logic [15:0] angle_a_o, angle_b_o, frame_cnt_o;
  logic [11:0] cx_o, cy_o;
  logic        timing_err_o;

  int   checks = 0;
  int   errors = 0;
  int   fs_count = 0;
  cfg_t cfg_a, cfg_b;
  logic exp_err;

  always #5 clk = ~clk;

  video_frame_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .cen_i         (cen),
    .vh_blank_i    (vh_blank),
    .cfg_valid_i   (cfg_valid),
    .cfg_ready_o   (cfg_ready),
    .cfg_step_a_i  (cfg_step_a),
    .cfg_step_b_i  (cfg_step_b),
    .cfg_cx_i      (cfg_cx),
    .cfg_cy_i      (cfg_cy),
    .pix_x_o       (pix_x_o),
    .pix_y_o       (pix_y_o),
    .active_o      (active_o),
    .frame_start_o (frame_start_o),
    .angle_a_o     (angle_a_o),
    .angle_b_o     (angle_b_o),
    .cx_o          (cx_o),
    .cy_o          (cy_o),
    .frame_cnt_o   (frame_cnt_o),
    .timing_err_o  (timing_err_o)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_line(input logic vb, input int npix, input logic exp_act, input int exp_y,
                           input bit half, input int cfg_pos, input cfg_t c);
    for (int i = 0; i < npix; i++) begin
      vh_blank   = {vb, 1'b0};
      cen        = 1'b1;
      cfg_valid  = (i == cfg_pos);
      cfg_step_a = c.step_a;
      cfg_step_b = c.step_b;
      cfg_cx     = c.cx;
      cfg_cy     = c.cy;
      tick();
      cfg_valid = 1'b0;
      if (frame_start_o === 1'b1) fs_count++;
      checks++;
      if (pix_x_o !== 12'(i)) begin
        errors++; $display("FAIL pix_x: got %0d expected %0d", pix_x_o, i);
      end
      checks++;
      if (active_o !== exp_act) begin
        errors++; $display("FAIL active: got %0b expected %0b (x=%0d)", active_o, exp_act, i);
      end
      if (i == 0 && exp_y >= 0) begin
        checks++;
        if (pix_y_o !== 12'(exp_y)) begin
          errors++; $display("FAIL pix_y: got %0d expected %0d", pix_y_o, exp_y);
        end
      end
      if (half) begin
        cen = 1'b0;
        tick();
        checks++;
        if (pix_x_o !== 12'(i) || active_o !== exp_act) begin
          errors++;
          $display("FAIL cen_hold: got x=%0d act=%0b expected x=%0d act=%0b", pix_x_o, active_o, i, exp_act);
        end
      end
    end
    for (int j = 0; j < HB; j++) begin
      vh_blank = {vb, 1'b1};
      cen      = 1'b1;
      tick();
      if (frame_start_o === 1'b1) fs_count++;
      checks++;
      if (active_o !== 1'b0 || pix_x_o !== 12'(npix - 1)) begin
        errors++;
        $display("FAIL hblank: got x=%0d act=%0b expected x=%0d act=0", pix_x_o, active_o, npix - 1);
      end
      if (half) begin
        cen = 1'b0;
        tick();
      end
    end
    cen = 1'b1;
  endtask

  // VB blanking lines (Vblank rises on the first) followed by V active lines.
  task automatic run_frame(input bit half, input int cl1, input int cp1,
                           input int cl2, input int cp2, input int short_line);
    for (int l = 0; l < VB + V; l++) begin
      int   pos;
      cfg_t c;
      pos = -1;
      c   = cfg_a;
      if (l == cl1) pos = cp1;
      else if (l == cl2) begin
        pos = cp2;
        c   = cfg_b;
      end
      if (l < VB) send_line(1'b1, H, 1'b0, -1, half, pos, c);
      else send_line(1'b0, (l == short_line) ? H - 1 : H, 1'b1, l - VB, half, pos, c);
    end
    $display("frame: cnt=%0d angle_a=%0d angle_b=%0d cx=%0d cy=%0d ready=%0b err=%0b",
             frame_cnt_o, angle_a_o, angle_b_o, cx_o, cy_o, cfg_ready, timing_err_o);
  endtask

  task automatic check_frame_state(input string tag, input int cnt, input int a, input int b,
                                   input int x, input int y, input logic rdy);
    checks++;
    if (frame_cnt_o !== 16'(cnt) || angle_a_o !== 16'(a) || angle_b_o !== 16'(b)) begin
      errors++;
      $display("FAIL %s angles: got cnt=%0d a=%0d b=%0d expected cnt=%0d a=%0d b=%0d",
               tag, frame_cnt_o, angle_a_o, angle_b_o, cnt, a, b);
    end
    checks++;
    if (cx_o !== 12'(x) || cy_o !== 12'(y) || cfg_ready !== rdy) begin
      errors++;
      $display("FAIL %s cfg: got cx=%0d cy=%0d ready=%0b expected cx=%0d cy=%0d ready=%0b",
               tag, cx_o, cy_o, cfg_ready, x, y, rdy);
    end
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if (pix_x_o !== 12'd0 || pix_y_o !== 12'd0 || active_o !== 1'b0 || frame_start_o !== 1'b0) begin
      errors++;
      $display("FAIL %s pix: got x=%0d y=%0d act=%0b fs=%0b expected all 0",
               tag, pix_x_o, pix_y_o, active_o, frame_start_o);
    end
    checks++;
    if (timing_err_o !== 1'b0) begin
      errors++; $display("FAIL %s timing_err: got %0b expected 0", tag, timing_err_o);
    end
    check_frame_state(tag, 0, 0, 0, 960, 540, 1'b1);
  endtask

  task automatic test_reset;
    rst_ni    = 1'b0;
    cen       = 1'b1;
    vh_blank  = 2'b01;
    cfg_valid = 1'b0;
    cfg_step_a = '0; cfg_step_b = '0; cfg_cx = '0; cfg_cy = '0;
    tick();
    tick();
    check_reset_values("reset");
    rst_ni = 1'b1;
  endtask

  task automatic test_frames;
    fs_count = 0;
    send_line(1'b0, H, 1'b0, -1, 1'b0, -1, cfg_a);
    checks++;
    if (frame_cnt_o !== 16'd0 || fs_count != 0) begin
      errors++; $display("FAIL sync_hold: got cnt=%0d fs=%0d expected 0 0", frame_cnt_o, fs_count);
    end
    run_frame(1'b0, -1, -1, -1, -1, -1);
    check_frame_state("lock", 0, 0, 0, 960, 540, 1'b1);
    run_frame(1'b0, -1, -1, -1, -1, -1);
    run_frame(1'b0, -1, -1, -1, -1, -1);
    checks++;
    if (fs_count != 3) begin
      errors++; $display("FAIL frame_start_count: got %0d expected 3", fs_count);
    end
    check_frame_state("three_frames", 2, 1310, 656, 960, 540, 1'b1);
    checks++;
    if (timing_err_o !== 1'b0) begin
      errors++; $display("FAIL timing_ok: got %0b expected 0", timing_err_o);
    end
  endtask

  task automatic test_config;
    cfg_a = '{step_a: 16'd100, step_b: 16'd200, cx: 12'd500, cy: 12'd300};
    run_frame(1'b0, VB + 1, 5, -1, -1, -1);
    check_frame_state("cfg_pending", 3, 1965, 984, 960, 540, 1'b0);
    run_frame(1'b0, -1, -1, -1, -1, -1);
    check_frame_state("cfg_applied", 4, 2620, 1312, 500, 300, 1'b1);
    run_frame(1'b0, -1, -1, -1, -1, -1);
    check_frame_state("cfg_new_step", 5, 2720, 1512, 500, 300, 1'b1);
  endtask

  task automatic test_back_to_back;
    cfg_a = '{step_a: 16'd1000, step_b: 16'd2000, cx: 12'd111, cy: 12'd222};
    cfg_b = '{step_a: 16'd7, step_b: 16'd7, cx: 12'd7, cy: 12'd7};
    run_frame(1'b0, 0, 0, VB + 2, 3, -1);
    check_frame_state("coincident_wait", 6, 2820, 1712, 500, 300, 1'b0);
    run_frame(1'b0, -1, -1, -1, -1, -1);
    check_frame_state("coincident_apply", 7, 2920, 1912, 111, 222, 1'b1);
    run_frame(1'b0, -1, -1, -1, -1, -1);
    check_frame_state("second_ignored", 8, 3920, 3912, 111, 222, 1'b1);
  endtask

  task automatic test_half_rate;
    fs_count = 0;
    run_frame(1'b1, -1, -1, -1, -1, -1);
    check_frame_state("half_rate", 9, 4920, 5912, 111, 222, 1'b1);
    checks++;
    if (fs_count != 1) begin
      errors++; $display("FAIL half_rate_fs: got %0d expected 1", fs_count);
    end
  endtask

  task automatic test_reset_midline;
    cfg_a = '{step_a: 16'd100, step_b: 16'd200, cx: 12'd500, cy: 12'd300};
    vh_blank   = 2'b00;
    cen        = 1'b1;
    cfg_valid  = 1'b1;
    cfg_step_a = cfg_a.step_a; cfg_step_b = cfg_a.step_b;
    cfg_cx     = cfg_a.cx;     cfg_cy     = cfg_a.cy;
    tick();
    cfg_valid = 1'b0;
    checks++;
    if (cfg_ready !== 1'b0) begin
      errors++; $display("FAIL midline_accept: got ready=%0b expected 0", cfg_ready);
    end
    tick();
    tick();
    cen    = 1'b0;
    rst_ni = 1'b0;
    tick();
    check_reset_values("reset_midline");
    rst_ni   = 1'b1;
    vh_blank = 2'b01;
    cen      = 1'b1;
    fs_count = 0;
    send_line(1'b0, H, 1'b0, -1, 1'b0, -1, cfg_a);
    run_frame(1'b0, -1, -1, -1, -1, -1);
    check_frame_state("relock", 0, 0, 0, 960, 540, 1'b1);
    run_frame(1'b0, -1, -1, -1, -1, -1);
    check_frame_state("relock_step", 1, 655, 328, 960, 540, 1'b1);
    checks++;
    if (fs_count != 2) begin
      errors++; $display("FAIL relock_fs: got %0d expected 2", fs_count);
    end
  endtask

  task automatic test_timing_err;
    run_frame(1'b0, -1, -1, -1, -1, VB + 1);
    checks++;
    if (timing_err_o !== exp_err) begin
      errors++; $display("FAIL short_line_err: got %0b expected %0b", timing_err_o, exp_err);
    end
    run_frame(1'b0, -1, -1, -1, -1, -1);
    checks++;
    if (timing_err_o !== exp_err) begin
      errors++; $display("FAIL err_sticky: got %0b expected %0b", timing_err_o, exp_err);
    end
    check_frame_state("after_short", 3, 1965, 984, 960, 540, 1'b1);
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    checks++;
    if (timing_err_o !== 1'b0) begin
      errors++; $display("FAIL err_reset: got %0b expected 0", timing_err_o);
    end
  endtask

  initial begin
`ifdef VIDEO_FRAME_CTRL_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    cfg_a = '{step_a: 16'd0, step_b: 16'd0, cx: 12'd0, cy: 12'd0};
    cfg_b = cfg_a;
    test_reset();
    test_frames();
    test_config();
    test_back_to_back();
    test_half_rate();
    test_reset_midline();
    test_timing_err();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
